// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the round-robin scheduler that fronts the serial sequence detector.
package seqdet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GUARD = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/seqdet_rr_arb.sv
// Combinational round-robin arbiter: first requester at or above ptr wins, wrapping to index 0.
module seqdet_rr_arb
  import seqdet_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int ID_W  = clog2(N_REQ) + 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    // Upper pass covers [ptr, N_REQ), wrap pass covers [0, ptr).
    for (int j = 0; j < N_REQ; j++) begin
      if (en && !found && req[j] && (ID_W'(j) >= ptr)) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (en && !found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/seqdet_stream_sched.sv
// Shares one serial sequence detector among N_REQ requesters: guard-flush, shift word MSB-first, count matches, respond.
// Handshakes: a transfer occurs on any cycle where valid & ready are both high; valid never depends on ready.
module seqdet_stream_sched
  import seqdet_pkg::*;
#(
  parameter  int N_REQ      = 2,
  parameter  int WORD_W     = 8,
  parameter  int GUARD_BITS = 4,
  parameter  int DET_LAT    = 1,
  localparam int CNT_W      = clog2(WORD_W + 1),
  localparam int ID_W       = clog2(N_REQ) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*WORD_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      det_in,
  input  logic                      det_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [CNT_W-1:0]          rsp_count,
  output logic                      busy,
  output logic [2:0]                cur_state
);

  localparam int K_END = GUARD_BITS + WORD_W + DET_LAT;
  localparam int K_W   = clog2(K_END + 1);
  localparam logic [K_W-1:0] K_GUARD_LAST = K_W'(GUARD_BITS - 1);
  localparam logic [K_W-1:0] K_SHIFT_LAST = K_W'(GUARD_BITS + WORD_W - 1);
  localparam logic [K_W-1:0] K_DRAIN_LAST = K_W'(K_END - 1);
  localparam logic [K_W-1:0] K_WIN_LO     = K_W'(GUARD_BITS + DET_LAT);
  localparam logic [K_W-1:0] K_WIN_HI     = K_W'(K_END);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shreg, word, shift_src;
  logic [K_W-1:0]      k;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [ID_W-1:0]     ptr, idx;
  logic [N_REQ-1:0]    grant;
  logic                accept, active, in_win;

  // Holding off grants while rst is low keeps req_ready quiet during reset.
  seqdet_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    ((state_q == ST_IDLE) && rst),
    .grant (grant),
    .idx   (idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign busy      = (state_q != ST_IDLE);
  assign cur_state = state_q;
  assign active    = (state_q == ST_GUARD) || (state_q == ST_SHIFT) || (state_q == ST_DRAIN);
  assign in_win    = (k >= K_WIN_LO) && (k < K_WIN_HI);
  assign shift_src = accept ? word : shreg;

  always_comb begin
    word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) word = req_data[i*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    if (active && in_win && det_out && (cnt != '1)) cnt_nxt = cnt + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (GUARD_BITS > 0) ? ST_GUARD : ST_SHIFT;
      ST_GUARD: if (k == K_GUARD_LAST) state_d = ST_SHIFT;
      ST_SHIFT: if (k == K_SHIFT_LAST) state_d = ST_DRAIN;
      ST_DRAIN: if (k == K_DRAIN_LAST) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shreg     <= '0;
      det_in    <= 1'b0;
      k         <= '0;
      cnt       <= '0;
      ptr       <= '0;
      rsp_id    <= '0;
      rsp_count <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= (state_d == ST_RESP);
      // det_in is loaded one cycle ahead so the bit is on the wire for the whole SHIFT cycle.
      if (state_d == ST_SHIFT) begin
        det_in <= shift_src[WORD_W-1];
        shreg  <= shift_src << 1;
      end else begin
        det_in <= 1'b0;
        if (accept) shreg <= word;
      end
      if (accept) begin
        rsp_id <= idx;
        ptr    <= (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
        k      <= '0;
        cnt    <= '0;
      end else if (active) begin
        k   <= k + 1'b1;
        cnt <= cnt_nxt;
      end
      if ((state_q == ST_DRAIN) && (state_d == ST_RESP)) rsp_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_seqdet_stream_sched.sv
// Directed bench for seqdet_stream_sched with a behavioural 10010 overlapping Moore detector (latency 1).
module tb_seqdet_stream_sched;

  localparam int N_REQ  = 2;
  localparam int WORD_W = 8;
  localparam int ID_W   = 2;
  localparam int CNT_W  = 4;
  localparam int RW     = ID_W + CNT_W;

  logic                     clk;
  logic                     rst;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*WORD_W-1:0]  req_data;
  logic [N_REQ-1:0]         req_ready;
  logic                     det_in;
  logic                     det_out;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [CNT_W-1:0]         rsp_count;
  logic                     busy;
  logic [2:0]               cur_state;

  logic [RW-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int pulses   = 0;
  logic [4:0] hist;

  seqdet_stream_sched #(
    .N_REQ(N_REQ), .WORD_W(WORD_W), .GUARD_BITS(4), .DET_LAT(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .det_in    (det_in),
    .det_out   (det_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .busy      (busy),
    .cur_state (cur_state)
  );

  // Clock and reset-aware detector model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hist <= '0;
    else      hist <= {hist[3:0], det_in};
  end
  assign det_out = (hist == 5'b10010);

  always @(posedge clk) if (rst && det_out) pulses++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for a grant, checks it, then waits for the response and checks it against the scoreboard.
  task automatic serve(input logic [1:0] exp_gnt, input bit drop, output logic [RW-1:0] got);
    int t;
    int lat;
    logic [RW-1:0] e;
    #1;
    t = 0;
    while (req_ready == '0 && t < 40) begin
      tick();
      t++;
    end
    chk("grant", 32'(req_ready), 32'(exp_gnt));
    tick();
    if (drop) req_valid = '0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("rsp_latency", 32'(lat), 32'd14);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    chk("rsp_id_count", 32'({rsp_id, rsp_count}), 32'(e));
    got = e;
  endtask

  initial begin
    logic [RW-1:0] held;
    logic [RW-1:0] got;
    logic [12:0]   det_exp;
    int            p0;
    int            seen;

    rst       = 1'b0;
    req_valid = 2'b11;
    req_data  = 16'hFFFF;
    rsp_ready = 1'b1;

    // 1: reset holds everything quiet even with requests pending
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_det_in",    32'(det_in),    32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
    end
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_rsp_count", 32'(rsp_count), 32'd0);
    chk("rst_state",     32'(cur_state), 32'd0);
    req_valid = '0;
    rst = 1'b1;
    tick();

    // 2: single word, cycle-exact det_in stream
    req_data  = {8'h00, 8'b1001_0010};
    req_valid = 2'b01;
    exp_q.push_back({2'd0, 4'd2});
    #1;
    chk("single_grant", 32'(req_ready), 32'b01);
    tick();
    req_valid = '0;
    det_exp = 13'b0000_10010010_0;
    for (int i = 0; i < 13; i++) begin
      chk("single_det_in", 32'(det_in), 32'(det_exp[12-i]));
      chk("single_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    got = exp_q.pop_front();
    chk("single_rsp", 32'({rsp_id, rsp_count}), 32'(got));
    tick();
    chk("single_rsp_done", 32'(rsp_valid), 32'd0);
    chk("single_idle",     32'(busy),      32'd0);

    // Short reset so the round-robin pointer starts from 0
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // 3: round-robin with both requesters valid continuously
    req_data  = {8'h00, 8'b1001_0100};
    req_valid = 2'b11;
    exp_q.push_back({2'd0, 4'd1});
    exp_q.push_back({2'd1, 4'd0});
    exp_q.push_back({2'd0, 4'd1});
    exp_q.push_back({2'd1, 4'd0});
    serve(2'b01, 1'b0, got);
    tick();
    serve(2'b10, 1'b0, got);
    tick();
    serve(2'b01, 1'b0, got);
    tick();
    serve(2'b10, 1'b0, got);
    tick();

    // 4: back-pressure on the response port
    rsp_ready = 1'b0;
    exp_q.push_back({2'd0, 4'd1});
    serve(2'b01, 1'b0, held);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_hold",  32'({rsp_id, rsp_count}), 32'(held));
      chk("bp_no_grant",  32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_idle",  32'(cur_state), 32'd0);
    chk("bp_release_grant", 32'(req_ready), 32'b10);
    exp_q.push_back({2'd1, 4'd0});
    serve(2'b10, 1'b0, got);
    req_valid = '0;
    tick();

    // 5: guard isolation; A's trailing 1001 completes a match only on the flush zero
    req_data  = {8'h00, 8'b0000_1001};
    req_valid = 2'b01;
    exp_q.push_back({2'd0, 4'd0});
    p0 = pulses;
    serve(2'b01, 1'b1, got);
    tick();
    chk("guard_out_of_window_pulse", 32'(pulses - p0), 32'd1);
    req_data  = {8'h00, 8'b0111_1111};
    req_valid = 2'b01;
    exp_q.push_back({2'd0, 4'd0});
    p0 = pulses;
    serve(2'b01, 1'b1, got);
    tick();
    chk("guard_b_pulses", 32'(pulses - p0), 32'd0);

    // 6: reset during SHIFT bit 3 abandons the word and clears the pointer
    req_data  = {8'b1001_0010, 8'b1001_0010};
    req_valid = 2'b01;
    #1;
    chk("midrst_grant", 32'(req_ready), 32'b01);
    tick();
    req_valid = '0;
    for (int i = 0; i < 7; i++) tick();
    chk("midrst_in_shift", 32'(cur_state), 32'd2);
    chk("midrst_bit3",     32'(det_in),    32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_busy",   32'(busy),      32'd0);
    chk("midrst_det_in", 32'(det_in),    32'd0);
    chk("midrst_state",  32'(cur_state), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    req_valid = 2'b11;
    #1;
    chk("midrst_ptr_reset", 32'(req_ready), 32'b01);
    req_valid = 2'b10;
    exp_q.push_back({2'd1, 4'd2});
    serve(2'b10, 1'b1, got);
    tick();
    req_valid = 2'b11;
    exp_q.push_back({2'd0, 4'd2});
    serve(2'b01, 1'b1, got);
    tick();
    chk("final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
